// File: rtl/syn_acortex_lb_mstr.sv
// syn_acortex_lb_mstr: host-to-local-bus master issuing one strobe per command and waiting for a per-slave ack or timeout
module syn_acortex_lb_mstr #(
   parameter int P_LB_DATA_W  = 16,
   parameter int P_LB_ADDR_W  = 8,
   parameter int P_NUM_SLAVES = 4,
   parameter int P_TIMEOUT    = 16
) (
   input  logic                              clk_ir,
   input  logic                              rst_sync_l,
   input  logic                              host_req_valid,
   output logic                              host_req_ready,
   input  logic                              host_req_wr,
   input  logic [P_LB_ADDR_W-1:0]            host_req_addr,
   input  logic [P_LB_DATA_W-1:0]            host_req_wdata,
   output logic                              host_rsp_valid,
   output logic [P_LB_DATA_W-1:0]            host_rsp_rdata,
   output logic                              host_rsp_err,
   output logic [P_LB_ADDR_W-1:0]            lb_addr,
   output logic [P_LB_DATA_W-1:0]            lb_wr_data,
   output logic [P_NUM_SLAVES-1:0]           lb_wr_en,
   output logic [P_NUM_SLAVES-1:0]           lb_rd_en,
   input  logic [P_NUM_SLAVES-1:0]           lb_wr_valid,
   input  logic [P_NUM_SLAVES-1:0]           lb_rd_valid,
   input  logic [P_NUM_SLAVES*P_LB_DATA_W-1:0] lb_rd_data
);
   localparam int CW = $clog2(P_TIMEOUT) + 1;
   localparam logic [CW-1:0] TO_LAST = CW'(P_TIMEOUT - 1);
   localparam logic [P_LB_DATA_W-1:0] DEAD = P_LB_DATA_W'(16'hDEAD);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t                  state_q, state_d;
   logic                    wr_q, wr_d;
   logic [1:0]              sel_q, sel_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [P_LB_ADDR_W-1:0]  addr_q, addr_d;
   logic [P_LB_DATA_W-1:0]  wdata_q, wdata_d;
   logic                    ready_q, ready_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [P_LB_DATA_W-1:0]  rdata_q, rdata_d;
   logic                    err_q, err_d;
   logic [P_NUM_SLAVES-1:0] wr_en_q, wr_en_d;
   logic [P_NUM_SLAVES-1:0] rd_en_q, rd_en_d;
   logic                    ack;
   logic [P_LB_DATA_W-1:0]  sel_rdata;
   // state and all output registers; reset aborts any pending command
   always_ff @(posedge clk_ir or negedge rst_sync_l) begin
      if (!rst_sync_l) begin
         state_q     <= IDLE;
         wr_q        <= 1'b0;
         sel_q       <= '0;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         wr_en_q     <= '0;
         rd_en_q     <= '0;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         sel_q       <= sel_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         wr_en_q     <= wr_en_d;
         rd_en_q     <= rd_en_d;
      end
   end
   // next state; strobes and response are computed one cycle early so outputs come straight from flops
   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      sel_d       = sel_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rdata_d     = rdata_q;
      err_d       = err_q;
      wr_en_d     = '0;
      rd_en_d     = '0;
      ack         = 1'b0;
      sel_rdata   = '0;
      for (int i = 0; i < P_NUM_SLAVES; i++) begin
         if (int'(sel_q) == i) begin
            ack       = wr_q ? lb_wr_valid[i] : lb_rd_valid[i];
            sel_rdata = lb_rd_data[i*P_LB_DATA_W +: P_LB_DATA_W];
         end
      end
      case (state_q)
         IDLE: begin
            if (host_req_valid && ready_q) begin
               wr_d    = host_req_wr;
               addr_d  = host_req_addr;
               wdata_d = host_req_wdata;
               sel_d   = host_req_addr[P_LB_ADDR_W-1 -: 2];
               state_d = ISSUE;
               for (int i = 0; i < P_NUM_SLAVES; i++) begin
                  if (int'(sel_d) == i) begin
                     wr_en_d[i] = host_req_wr;
                     rd_en_d[i] = !host_req_wr;
                  end
               end
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (ack) begin
               rdata_d     = wr_q ? '0 : sel_rdata;
               err_d       = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else if (cnt_q == TO_LAST) begin
               rdata_d     = DEAD;
               err_d       = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
   end
   assign host_req_ready = ready_q;
   assign host_rsp_valid = rsp_valid_q;
   assign host_rsp_rdata = rdata_q;
   assign host_rsp_err   = err_q;
   assign lb_addr        = addr_q;
   assign lb_wr_data     = wdata_q;
   assign lb_wr_en       = wr_en_q;
   assign lb_rd_en       = rd_en_q;
endmodule

// File: tb/tb_syn_acortex_lb_mstr.sv
// tb_syn_acortex_lb_mstr: table-driven bench for the local bus master with reset corner sequences
module tb_syn_acortex_lb_mstr;
   logic        clk_ir = 1'b0;
   logic        rst_sync_l = 1'b0;
   logic        host_req_valid = 1'b0;
   logic        host_req_ready;
   logic        host_req_wr = 1'b0;
   logic [7:0]  host_req_addr = '0;
   logic [15:0] host_req_wdata = '0;
   logic        host_rsp_valid;
   logic [15:0] host_rsp_rdata;
   logic        host_rsp_err;
   logic [7:0]  lb_addr;
   logic [15:0] lb_wr_data;
   logic [3:0]  lb_wr_en;
   logic [3:0]  lb_rd_en;
   logic [3:0]  lb_wr_valid = '0;
   logic [3:0]  lb_rd_valid = '0;
   logic [63:0] lb_rd_data = '0;
   int checks = 0;
   int fails = 0;
   syn_acortex_lb_mstr dut (
      .clk_ir(clk_ir), .rst_sync_l(rst_sync_l),
      .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
      .host_req_wr(host_req_wr), .host_req_addr(host_req_addr), .host_req_wdata(host_req_wdata),
      .host_rsp_valid(host_rsp_valid), .host_rsp_rdata(host_rsp_rdata), .host_rsp_err(host_rsp_err),
      .lb_addr(lb_addr), .lb_wr_data(lb_wr_data), .lb_wr_en(lb_wr_en), .lb_rd_en(lb_rd_en),
      .lb_wr_valid(lb_wr_valid), .lb_rd_valid(lb_rd_valid), .lb_rd_data(lb_rd_data)
   );
   always #5 clk_ir = ~clk_ir;
   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [15:0] wdata;
      int          ack_d;
      int          ack_idx;
      logic        ack_wr;
      logic [15:0] sdata;
      logic        distract;
      logic [3:0]  exp_en;
      logic [15:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;
   vec_t vecs[9];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask
   task automatic run_vec(input int id, input vec_t v);
      int lat;
      lat = 0;
      for (int k = 0; k < 40 && !host_req_ready; k++) @(negedge clk_ir);
      chk($sformatf("v%0d_ready", id), {31'b0, host_req_ready}, 32'd1);
      for (int i = 0; i < 4; i++) lb_rd_data[i*16 +: 16] = (i == v.ack_idx) ? v.sdata : (16'hBAD0 | 16'(i));
      host_req_valid = 1'b1;
      host_req_wr    = v.wr;
      host_req_addr  = v.addr;
      host_req_wdata = v.wdata;
      @(negedge clk_ir);
      chk($sformatf("v%0d_strobe", id), {24'b0, lb_wr_en, lb_rd_en}, v.wr ? {24'b0, v.exp_en, 4'b0} : {28'b0, v.exp_en});
      chk($sformatf("v%0d_busy", id), {31'b0, host_req_ready}, 32'd0);
      host_req_wr    = ~v.wr;
      host_req_addr  = ~v.addr;
      host_req_wdata = ~v.wdata;
      for (int k = 1; k <= 30; k++) begin
         if (k > 1) @(negedge clk_ir);
         if (k == 2) begin
            chk($sformatf("v%0d_strobe_off", id), {24'b0, lb_wr_en, lb_rd_en}, 32'd0);
            chk($sformatf("v%0d_lb_addr", id), {24'b0, lb_addr}, {24'b0, v.addr});
            chk($sformatf("v%0d_lb_wdata", id), {16'b0, lb_wr_data}, {16'b0, v.wdata});
         end
         if (host_rsp_valid) begin
            lat = k;
            break;
         end
         lb_wr_valid = (v.ack_d > 0 && k == 1 + v.ack_d && v.ack_wr) ? (4'b1 << v.ack_idx) : 4'b0;
         lb_rd_valid = (v.ack_d > 0 && k == 1 + v.ack_d && !v.ack_wr) ? (4'b1 << v.ack_idx) : 4'b0;
         if (v.distract && k == 2) lb_rd_valid[0] = 1'b1;
      end
      lb_wr_valid = '0;
      lb_rd_valid = '0;
      host_req_valid = 1'b0;
      chk($sformatf("v%0d_latency", id), lat, v.exp_lat);
      chk($sformatf("v%0d_rdata", id), {16'b0, host_rsp_rdata}, {16'b0, v.exp_rdata});
      chk($sformatf("v%0d_err", id), {31'b0, host_rsp_err}, {31'b0, v.exp_err});
      @(negedge clk_ir);
      chk($sformatf("v%0d_rsp_pulse", id), {31'b0, host_rsp_valid}, 32'd0);
      chk($sformatf("v%0d_ready_again", id), {31'b0, host_req_ready}, 32'd1);
   endtask
   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      int bad;
      vecs[0] = '{1'b1, 8'h00, 16'h8002, 1,  0, 1'b1, 16'h0000, 1'b0, 4'b0001, 16'h0000, 1'b0, 3};
      vecs[1] = '{1'b0, 8'h40, 16'h0000, 1,  1, 1'b0, 16'h1234, 1'b0, 4'b0010, 16'h1234, 1'b0, 3};
      vecs[2] = '{1'b0, 8'h80, 16'h0000, 0,  2, 1'b0, 16'h7777, 1'b0, 4'b0100, 16'hDEAD, 1'b1, 18};
      vecs[3] = '{1'b0, 8'hC0, 16'h0000, 5,  3, 1'b0, 16'h5A5A, 1'b1, 4'b1000, 16'h5A5A, 1'b0, 7};
      vecs[4] = '{1'b0, 8'h80, 16'h0000, 16, 2, 1'b0, 16'hBEEF, 1'b0, 4'b0100, 16'hBEEF, 1'b0, 18};
      vecs[5] = '{1'b1, 8'h40, 16'h1111, 1,  1, 1'b0, 16'h2222, 1'b0, 4'b0010, 16'hDEAD, 1'b1, 18};
      vecs[6] = '{1'b1, 8'hC5, 16'hCAFE, 2,  3, 1'b1, 16'h9999, 1'b0, 4'b1000, 16'h0000, 1'b0, 4};
      vecs[7] = '{1'b0, 8'h7F, 16'h0000, 1,  2, 1'b0, 16'h4444, 1'b0, 4'b0010, 16'hDEAD, 1'b1, 18};
      vecs[8] = '{1'b0, 8'h81, 16'h0000, 17, 2, 1'b0, 16'h5555, 1'b0, 4'b0100, 16'hDEAD, 1'b1, 18};
      repeat (2) @(negedge clk_ir);
      chk("rst_ready", {31'b0, host_req_ready}, 32'd0);
      chk("rst_rsp", {14'b0, host_rsp_valid, host_rsp_err, host_rsp_rdata}, 32'd0);
      chk("rst_lb", {lb_addr, lb_wr_data, lb_wr_en, lb_rd_en}, 32'd0);
      rst_sync_l = 1'b1;
      #1 chk("rst_release_ready", {31'b0, host_req_ready}, 32'd0);
      @(negedge clk_ir);
      chk("post_rst_ready", {31'b0, host_req_ready}, 32'd1);
      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);
      host_req_valid = 1'b1;
      host_req_wr    = 1'b0;
      host_req_addr  = 8'h80;
      @(negedge clk_ir);
      host_req_valid = 1'b0;
      repeat (4) @(negedge clk_ir);
      #2 rst_sync_l = 1'b0;
      #1;
      chk("mid_rst_ready", {31'b0, host_req_ready}, 32'd0);
      chk("mid_rst_rsp", {14'b0, host_rsp_valid, host_rsp_err, host_rsp_rdata}, 32'd0);
      chk("mid_rst_lb", {lb_addr, lb_wr_data, lb_wr_en, lb_rd_en}, 32'd0);
      repeat (3) @(negedge clk_ir);
      rst_sync_l = 1'b1;
      bad = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk_ir);
         if (host_rsp_valid || lb_wr_en != 4'b0 || lb_rd_en != 4'b0) bad++;
      end
      chk("abort_no_activity", bad, 0);
      run_vec(9, vecs[1]);
      run_vec(10, vecs[0]);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/syn_acortex_lb_mstr.md
SYN_ACORTEX_LB_MSTR -- requirements
Module: syn_acortex_lb_mstr

Interface
REQ-001 SHALL have parameter P_LB_DATA_W, default 16, local bus data width.
REQ-002 SHALL have parameter P_LB_ADDR_W, default 8, local bus address width.
REQ-003 SHALL have parameter P_NUM_SLAVES, default 4, number of local bus responders; slave index = addr[P_LB_ADDR_W-1 -: 2].
REQ-004 SHALL have parameter P_TIMEOUT, default 16, maximum WAIT cycles before error.
REQ-005 clk_ir  in  1  single clock; all logic on posedge.
REQ-006 rst_sync_l  in  1  reset, asynchronous, active-low.
REQ-007 host_req_valid  in  1  host command valid.
REQ-008 host_req_ready  out  1  command accepted when valid&ready.
REQ-009 host_req_wr  in  1  1=write, 0=read.
REQ-010 host_req_addr  in  P_LB_ADDR_W  register address.
REQ-011 host_req_wdata  in  P_LB_DATA_W  write data.
REQ-012 host_rsp_valid  out  1  one-cycle response strobe.
REQ-013 host_rsp_rdata  out  P_LB_DATA_W  read data (0 for writes).
REQ-014 host_rsp_err  out  1  timeout flag, qualified by host_rsp_valid.
REQ-015 lb_addr  out  P_LB_ADDR_W  address broadcast to all slaves (full address, undecoded).
REQ-016 lb_wr_data  out  P_LB_DATA_W  write data broadcast.
REQ-017 lb_wr_en  out  P_NUM_SLAVES  per-slave write strobe.
REQ-018 lb_rd_en  out  P_NUM_SLAVES  per-slave read strobe.
REQ-019 lb_wr_valid  in  P_NUM_SLAVES  per-slave write acknowledge.
REQ-020 lb_rd_valid  in  P_NUM_SLAVES  per-slave read acknowledge.
REQ-021 lb_rd_data  in  P_NUM_SLAVES*P_LB_DATA_W  slave i read data at bits [i*W +: W].

Function
REQ-022 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, all registered outputs.
REQ-023 IDLE: host_req_ready=1; on valid&ready latch wr, addr, wdata, slave index; go ISSUE. Ready=0 in all other states.
REQ-024 ISSUE (1 cycle): assert lb_wr_en[sel] or lb_rd_en[sel] for exactly one cycle, all other en bits 0; clear timeout counter; go WAIT.
REQ-025 lb_addr and lb_wr_data SHALL hold latched values from ISSUE through end of WAIT.
REQ-026 WAIT: ack = lb_wr_valid[sel] (write) or lb_rd_valid[sel] (read); acks on unselected indices or wrong type ignored.
REQ-027 On ack: capture lb_rd_data[sel] for reads (0 for writes), err=0, go RESP.
REQ-028 No ack: counter increments per WAIT cycle; when counter reaches P_TIMEOUT-1 without ack -> rdata=16'hDEAD, err=1, go RESP; ack in that same cycle wins (err=0).
REQ-029 RESP (1 cycle): host_rsp_valid=1 with rdata/err; go IDLE. No response backpressure.
REQ-030 Minimum latency with a slave acking one cycle after strobe: accept at cycle N, strobe N+1, ack N+2, host_rsp_valid N+3; next accept N+4.
REQ-031 Slave index >= P_NUM_SLAVES SHALL issue no strobe and complete via timeout with 16'hDEAD, err=1.
REQ-032 host_req_* changes while not IDLE SHALL have no effect.
REQ-033 Timeout counter width $clog2(P_TIMEOUT)+1; no wrap before timeout.

Reset
REQ-034 On rst_sync_l low, asynchronously: state=IDLE, host_req_ready=0 until first clock after release then 1, host_rsp_valid=0, host_rsp_rdata=0, host_rsp_err=0, lb_wr_en=0, lb_rd_en=0, lb_addr=0, lb_wr_data=0, counter=0.
REQ-035 Reset mid-transaction SHALL abort with no response and no further strobes; the pending command is discarded.

Verification
REQ-036 Write addr 8'h00 data 16'h8002, slave 0 acks 1 cycle after strobe -> lb_wr_en=4'b0001 one cycle, rsp_valid 3 cycles after accept, rdata=0, err=0.
REQ-037 Read addr 8'h40, slave 1 returns 16'h1234 -> lb_rd_en=4'b0010 one cycle, rsp rdata=16'h1234, err=0.
REQ-038 Read addr 8'h80, slave 2 never acks -> rsp after 16 WAIT cycles, rdata=16'hDEAD, err=1.
REQ-039 Read to slave 3 while slave 0 pulses lb_rd_valid -> ignored; slave 3 ack 5 cycles later -> correct slave 3 data.
REQ-040 Ack arrives on final timeout cycle -> err=0, slave data returned.
REQ-041 Assert rst_sync_l low during WAIT -> all outputs 0 immediately, no rsp_valid; next command after release completes normally.
